// File: rtl/hippo_decode_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hippo_decoder_DecoderPkg (package)
//  Purpose  : Shared types for the RV32I decode stage: opcode constants,
//             ALU operand mux selects, funct7 constants, the DecodedInstr
//             record and immediate-extraction helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package hippo_decoder_DecoderPkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_ALUI   = 7'b0010011,
    OP_ALU    = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } Op;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } AluAMux;

  typedef enum logic [0:0] {
    B_RS2 = 1'b0,
    B_IMM = 1'b1
  } AluBMux;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SL  = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rf_we;
    AluAMux      a_sel;
    AluBMux      b_sel;
    logic [2:0]  alu_op;
    logic        sub;
    logic [2:0]  funct3;
    logic        branch;
    logic        jump;
    logic        mem_we;
    logic        load;
    logic        csr;
    logic        muldiv;
    logic        trap;
  } DecodedInstr;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hippo_decode_stage_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : hippo_decode_fifo
//  Purpose  : DEPTH-entry synchronous FIFO with a generic payload width.
//             Pointers carry one extra wrap bit: full when the wrap bits
//             differ and the index bits match. Flush empties it next cycle.
//  Ports    : clk, rst (sync, active-high), flush, push, pop, din,
//             full, empty, dout (zero while empty)
//  Revision : 1.0 - initial release
// ============================================================================
module hippo_decode_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; the output is masked while empty instead.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/hippo_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : hippo_decode_stage
//  Purpose  : Registered RV32I decode stage. Each accepted instruction is
//             decoded combinationally and queued as a DecodedInstr record in
//             a DEPTH-entry FIFO towards execute. Illegal encodings (and, in
//             RV32E mode, register indices >= 16) produce trap records that
//             flow through like any other record.
//  Macro    : HIPPO_DECODE_MULDIV_EN - when defined, OP with funct7=0x01
//             decodes as a mul/div operation instead of trapping.
//  Ports    : i_clk, i_reset (sync, active-high), i_flush,
//             i_valid/o_ready/i_instr/i_pc  - upstream beat
//             o_valid/i_ready/o_dec         - head record
//             o_count                        - saturating accept counter
//  Revision : 1.0 - initial release
// ============================================================================
module hippo_decode_stage
  import hippo_decoder_DecoderPkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RV32E = 0,
  parameter int CNT_W = 16
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_flush,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [31:0]                    i_instr,
  input  logic [31:0]                    i_pc,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [$bits(DecodedInstr)-1:0] o_dec,
  output logic [CNT_W-1:0]               o_count
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  DecodedInstr dec;
  logic        use_rs1;
  logic        use_rs2;
  logic        use_rd;
  logic        illegal;
  logic        full;
  logic        empty;
  logic        accept;

  assign opcode = i_instr[6:0];
  assign rd     = i_instr[11:7];
  assign funct3 = i_instr[14:12];
  assign rs1    = i_instr[19:15];
  assign rs2    = i_instr[24:20];
  assign funct7 = i_instr[31:25];

  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    illegal = 1'b0;
    dec.pc  = i_pc;
    case (opcode)
      OP_LUI: begin
        use_rd = 1'b1; dec.imm = imm_u(i_instr); dec.rf_we = 1'b1;
        dec.a_sel = A_ZERO; dec.b_sel = B_IMM;
      end
      OP_AUIPC: begin
        use_rd = 1'b1; dec.imm = imm_u(i_instr); dec.rf_we = 1'b1;
        dec.a_sel = A_PC; dec.b_sel = B_IMM;
      end
      OP_JAL: begin
        use_rd = 1'b1; dec.imm = imm_j(i_instr); dec.rf_we = 1'b1; dec.jump = 1'b1;
        dec.a_sel = A_PC; dec.b_sel = B_IMM;
      end
      OP_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i(i_instr); dec.rf_we = 1'b1;
        dec.jump = 1'b1; dec.b_sel = B_IMM; dec.funct3 = funct3;
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.imm = imm_b(i_instr);
        dec.branch = 1'b1; dec.funct3 = funct3;
      end
      OP_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i(i_instr); dec.rf_we = 1'b1;
        dec.load = 1'b1; dec.b_sel = B_IMM; dec.funct3 = funct3;
      end
      OP_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.imm = imm_s(i_instr);
        dec.mem_we = 1'b1; dec.b_sel = B_IMM; dec.funct3 = funct3;
      end
      OP_ALUI: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i(i_instr); dec.rf_we = 1'b1;
        dec.b_sel = B_IMM; dec.alu_op = funct3; dec.funct3 = funct3;
        // Shift immediates reuse imm[11:5] as funct7; only SRAI may use ALT.
        if (funct3 == F3_SL && funct7 != F7_BASE) illegal = 1'b1;
        if (funct3 == F3_SR) begin
          if (funct7 == F7_ALT)       dec.sub = 1'b1;
          else if (funct7 != F7_BASE) illegal = 1'b1;
        end
      end
      OP_ALU: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; dec.rf_we = 1'b1;
        dec.alu_op = funct3; dec.funct3 = funct3;
        if (funct7 == F7_BASE) begin
          dec.sub = 1'b0;
        end else if (funct7 == F7_ALT) begin
          if (funct3 == F3_ADD || funct3 == F3_SR) dec.sub = 1'b1;
          else                                    illegal = 1'b1;
`ifdef HIPPO_DECODE_MULDIV_EN
        end else if (funct7 == F7_MULDIV) begin
          dec.muldiv = 1'b1;
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      OP_FENCE: begin
        dec.funct3 = funct3;
      end
      OP_SYSTEM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i(i_instr); dec.rf_we = 1'b1;
        dec.csr = 1'b1; dec.b_sel = B_IMM; dec.funct3 = funct3;
      end
      default: illegal = 1'b1;
    endcase

    dec.rs1 = use_rs1 ? rs1 : 5'd0;
    dec.rs2 = use_rs2 ? rs2 : 5'd0;
    dec.rd  = use_rd  ? rd  : 5'd0;

    if ((RV32E != 0) && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4])))
      illegal = 1'b1;

    // A trap record keeps only its pc so execute can report the fault.
    if (illegal) begin
      dec      = '0;
      dec.pc   = i_pc;
      dec.trap = 1'b1;
    end
  end

  hippo_decode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(DecodedInstr))
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .flush (i_flush),
    .push  (i_valid),
    .pop   (i_ready),
    .din   (dec),
    .full  (full),
    .empty (empty),
    .dout  (o_dec)
  );

  assign o_ready = !full;
  assign o_valid = !empty;
  assign accept  = i_valid && o_ready;

  // Counts every accept, including one discarded by a same-cycle flush.
  always_ff @(posedge i_clk) begin
    if (i_reset)                    o_count <= '0;
    else if (accept && !(&o_count)) o_count <= o_count + CNT_W'(1);
  end

endmodule
`default_nettype wire
